clock_enable_gen: RTL

- Parametrised successor to the fixed clock divider that derives clk_vga/clk_ppu/clk_cpu from CLOCK_50.
- Generates NUM_CH independent, runtime-programmable clock-enable strobes plus matching square waves, all from the single CLOCK_50 domain. No derived clocks.
- Divisor changes are glitch-free: applied only at a channel's terminal count.
- A global sync realigns all channels to phase 0, e.g. to start CPU/PPU/VGA in lockstep after program load.

---
 rtl/clock_enable_gen.sv | 102 ++++++++++
 1 files changed

// File: rtl/clock_enable_gen.sv
// Per-channel programmable clock-enable strobes and square waves, all in the CLOCK_50 domain.
// Divisor writes are held pending and only take effect at a terminal count, while idle, or on sync.
module clock_enable_gen #(
   parameter int                          NUM_CH  = 3,
   parameter int                          DIV_W   = 8,
   parameter int                          CH_W    = 2,
   parameter logic [NUM_CH*DIV_W-1:0]     DEF_DIV = {8'd16, 8'd8, 8'd2}
) (
   input  logic                 CLOCK_50,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic [DIV_W-1:0]     cfg_div,
   input  logic [NUM_CH-1:0]    ch_en,
   input  logic                 sync,
   output logic [NUM_CH-1:0]    ce,
   output logic [NUM_CH-1:0]    clk_sq,
   output logic [NUM_CH-1:0]    pending
);

   logic [NUM_CH-1:0][DIV_W-1:0] cnt, cnt_nx;
   logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_nx;
   logic [NUM_CH-1:0][DIV_W-1:0] pdiv, pdiv_nx;
   logic [NUM_CH-1:0]            pend_nx, ce_nx, sq_nx;

   always_comb begin
      logic              run;
      logic              wrap;
      logic              we_hit;
      logic [DIV_W-1:0]  eff;
      logic [DIV_W-1:0]  cnt_inc;
      logic [DIV_W:0]    half;
      cnt_nx  = cnt;
      div_nx  = div_q;
      pdiv_nx = pdiv;
      pend_nx = pending;
      ce_nx   = '0;
      sq_nx   = clk_sq;
      run     = 1'b0;
      wrap    = 1'b0;
      we_hit  = 1'b0;
      eff     = '0;
      cnt_inc = '0;
      half    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         run     = ch_en[i] && (div_q[i] != '0);
         wrap    = run && (cnt[i] == div_q[i] - 1'b1);
         we_hit  = cfg_we && (cfg_ch == i[CH_W-1:0]);
         eff     = pending[i] ? pdiv[i] : div_q[i];
         cnt_inc = cnt[i] + 1'b1;
         half    = ({1'b0, div_q[i]} + 1'b1) >> 1;
         if (sync) begin
            div_nx[i]  = eff;
            pend_nx[i] = 1'b0;
            cnt_nx[i]  = '0;
            sq_nx[i]   = (eff != '0);
         end else if (!run) begin
            if (pending[i]) begin
               div_nx[i]  = pdiv[i];
               pend_nx[i] = 1'b0;
               cnt_nx[i]  = '0;
            end
         end else if (wrap) begin
            // The wrap strobe belongs to the old period even when a new divisor lands here.
            ce_nx[i]  = 1'b1;
            sq_nx[i]  = 1'b1;
            cnt_nx[i] = '0;
            if (pending[i]) begin
               div_nx[i]  = pdiv[i];
               pend_nx[i] = 1'b0;
            end
         end else begin
            cnt_nx[i] = cnt_inc;
            sq_nx[i]  = ({1'b0, cnt_inc} < half);
         end
         // A write always lands after this cycle's apply, so it is never consumed the same cycle.
         if (we_hit) begin
            pdiv_nx[i] = cfg_div;
            pend_nx[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         div_q   <= DEF_DIV;
         pdiv    <= '0;
         pending <= '0;
         ce      <= '0;
         clk_sq  <= '0;
      end else begin
         cnt     <= cnt_nx;
         div_q   <= div_nx;
         pdiv    <= pdiv_nx;
         pending <= pend_nx;
         ce      <= ce_nx;
         clk_sq  <= sq_nx;
      end
   end

endmodule
